regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised general-purpose register file with two combinational read ports, one write-back port and a per-register busy scoreboard.
//  Sits between decode (read/issue) and write-back. Adds write-to-read bypass, an optional hardwired-zero register, in-flight tracking and a busy counter.
//  Decode stalls on busy_a/busy_b/!issue_ready. Write-back clears busy and commits data in the same cycle.
// PARAMETERS
//  WIDTH     32  data word width in bits
//  DEPTH     32  number of registers, must be >= 2
//  ZERO_REG  1   1: register 0 always reads 0, writes/issues to it are ignored
//  BYPASS    1   1: same-cycle write-back data is forwarded to read ports
//  AW        $clog2(DEPTH) address width (derived, do not override)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset (0 = reset asserted)
//  rd_addr_a    in   AW     read port A address
//  rd_addr_b    in   AW     read port B address
//  rd_data_a    out  WIDTH  read port A data (combinational)
//  rd_data_b    out  WIDTH  read port B data (combinational)
//  busy_a       out  1      register at rd_addr_a has a pending write
//  busy_b       out  1      register at rd_addr_b has a pending write
//  wb_en        in   1      write-back valid
//  wb_addr      in   AW     write-back destination
//  wb_data      in   WIDTH  write-back data
//  issue_en     in   1      decode requests to claim issue_dst
//  issue_dst    in   AW     destination register being claimed
//  issue_ready  out  1      claim would be accepted this cycle
//  busy_count   out  AW+1   number of registers currently busy
// BEHAVIOUR
//  - Reset (reset=0, async): all registers <= 0, all busy bits <= 0, busy_count <= 0. Outputs read 0 and not-busy.
//  - Write: on posedge clk, if wb_en and not (ZERO_REG and wb_addr==0), then regs[wb_addr] <= wb_data. Latency 1 cycle to storage.
//  - Read: rd_data_x = 0 if ZERO_REG and addr==0.
//    Else wb_data if BYPASS and wb_en and wb_addr==addr.
//    Else regs[addr].
//  - busy_x = busy[addr] and not (wb_en and wb_addr==addr); always 0 for reg 0 when ZERO_REG. With BYPASS=0 the write-back clear is not applied to busy_x.
//  - issue_ready = not busy[issue_dst] or (wb_en and wb_addr==issue_dst), i.e. the WAW hazard resolves same cycle. Forced 1 for reg 0 when ZERO_REG.
//  - Accepted issue = issue_en and issue_ready. On posedge it sets busy[issue_dst], except reg 0 when ZERO_REG.
//  - Write-back clears busy[wb_addr] on posedge.
//  - Simultaneous issue and write-back to the same register: the data is written and busy ends SET (the new claim wins).
//  - Write-back to a non-busy register is legal: data is written and busy stays 0. No error is raised.
//  - Issue not accepted (issue_en and !issue_ready): no state change. Decode must hold its request.
//  - busy_count is a registered counter: +1 on each accepted issue that sets a previously-clear bit, -1 on each clear of a set bit.
//    Net 0 when both happen in the same cycle. Never wraps; it is bounded by DEPTH (minus 1 when ZERO_REG).
//  - Addresses >= DEPTH (non-power-of-2 DEPTH): reads return 0, writes/issues ignored, busy_x=0, issue_ready=1.
//  - Reset asserted mid-operation discards all pending claims and data. No partial update on the deasserting edge.
// STRUCTURE
//  - Shared package regfile_pkg: localparam helper function for AW, and the typedef reg_addr_t/reg_data_t keyed on WIDTH/DEPTH.
//  - One sub-module, busy_scoreboard: DEPTH busy flops, set/clear logic, busy_count counter, issue_ready and busy_a/busy_b lookups.
//  - Top: data storage array, write logic, bypass muxes, zero-register gating.
// TESTING
//  1. Reset: drive reset=0 mid-run after writing r5=0xDEADBEEF -> rd_data(5)=0, busy_count=0, issue_ready=1 immediately (async).
//  2. Write then read: wb r3=0x12345678, next cycle rd_addr_a=3 -> 0x12345678.
//     With BYPASS=1, same-cycle read of r3 during wb -> 0x12345678; with BYPASS=0 -> old value.
//  3. Zero reg: wb r0=0xFFFFFFFF, issue r0 -> rd r0=0, busy_a=0, busy_count unchanged.
//     Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
//  4. Scoreboard: issue r7 -> busy_a(7)=1, busy_count=1. Second issue r7 -> issue_ready=0, count stays 1.
//     wb r7=0xA5 -> busy_a drops in the wb cycle, count=0.
//  5. Simultaneous: r9 busy; same cycle issue r9 and wb r9=0x55 -> issue_ready=1, r9=0x55, busy[9]=1, count unchanged.
//  6. Fill: issue r1..r31 back to back -> busy_count=31. Write back all -> count=0 with no wrap or underflow.
//     A wb to a non-busy reg leaves count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file / scoreboard slice.
// The typedefs describe the default 32 x 32 configuration.
package regfile_pkg;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = addr_width(DEF_DEPTH);

    typedef logic [DEF_WIDTH-1:0] reg_data_t;
    typedef logic [DEF_AW-1:0]    reg_addr_t;

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy flags tracking in-flight writes, plus a registered count
// of busy registers and the issue/read hazard lookups derived from them.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_dst,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic          issue_ready,
    output logic [AW:0]   busy_count
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             issue_accept;
    logic             wb_clear;
    logic             count_inc;
    logic             count_dec;

    // Out-of-range addresses and a hardwired zero register are never tracked.
    function automatic logic tracked(input logic [AW-1:0] addr);
        return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    function automatic logic busy_at(input logic [AW-1:0] addr);
        return tracked(addr) && busy[addr];
    endfunction

    function automatic logic wb_hit(input logic [AW-1:0] addr);
        return wb_en && (wb_addr == addr);
    endfunction

    always_comb begin
        busy_a       = busy_at(rd_addr_a) && !(BYPASS && wb_hit(rd_addr_a));
        busy_b       = busy_at(rd_addr_b) && !(BYPASS && wb_hit(rd_addr_b));
        issue_ready  = !busy_at(issue_dst) || wb_hit(issue_dst);
        issue_accept = issue_en && issue_ready && tracked(issue_dst);
        wb_clear     = wb_en && tracked(wb_addr);
        count_inc    = issue_accept && !busy_at(issue_dst);
        count_dec    = wb_clear && busy_at(wb_addr)
                       && !(issue_accept && (issue_dst == wb_addr));

        // Clear first so a same-cycle claim on the same register wins.
        busy_next = busy;
        if (wb_clear) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_next;
            case ({count_inc, count_dec})
                2'b10:   busy_count <= busy_count + {{AW{1'b0}}, 1'b1};
                2'b01:   busy_count <= busy_count - {{AW{1'b0}}, 1'b1};
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port,
// optional write-to-read bypass, optional zero register and busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_dst,
    output logic             issue_ready,
    output logic [AW:0]      busy_count
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             write_en;

    function automatic logic storable(input logic [AW-1:0] addr);
        return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        if (!storable(addr)) begin
            return '0;
        end else if (BYPASS && wb_en && (wb_addr == addr)) begin
            return wb_data;
        end else begin
            return regs[addr];
        end
    endfunction

    always_comb begin
        write_en  = wb_en && storable(wb_addr);
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    busy_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .issue_en    (issue_en),
        .issue_dst   (issue_dst),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: scripted vector table, randomized run against a
// reference model, and hand sequences for reset, fill and drain.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wb_addr, issue_dst;
    logic [31:0] wb_data;
    logic        wb_en, issue_en;

    logic [31:0] rd_data_a, rd_data_b, alt_rd_data_a, alt_rd_data_b;
    logic        busy_a, busy_b, issue_ready;
    logic        alt_busy_a, alt_busy_b, alt_issue_ready;
    logic [5:0]  busy_count, alt_busy_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_dst(issue_dst),
        .issue_ready(issue_ready), .busy_count(busy_count)
    );

    regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_alt (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(alt_rd_data_a), .rd_data_b(alt_rd_data_b),
        .busy_a(alt_busy_a), .busy_b(alt_busy_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_dst(issue_dst),
        .issue_ready(alt_issue_ready), .busy_count(alt_busy_count)
    );

    // Reference model of the default (ZERO_REG=1, BYPASS=1) instance.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic logic model_ready();
        return (issue_dst == 0) || !m_busy[issue_dst] || (wb_en && wb_addr == issue_dst);
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic void model_commit();
        logic accept;
        accept = issue_en && model_ready();
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (accept && issue_dst != 0) m_busy[issue_dst] = 1'b1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic ie, input logic [4:0] id,
                                  input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        wb_en = we; wb_addr = wa; wb_data = wd;
        issue_en = ie; issue_dst = id;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
    endtask

    task automatic commit_cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    typedef struct {
        logic [31:0] wb_en, wb_addr, wb_data, issue_en, issue_dst, rd_a, rd_b;
        logic [31:0] exp_a, exp_b, exp_busy_a, exp_busy_b, exp_ready, exp_count;
        logic [31:0] exp_alt_a, exp_alt_busy_a;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1, 3, 32'h12345678, 0, 0, 3, 5, 32'h12345678, 0, 0, 0, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 3, 0, 32'h12345678, 0, 0, 0, 1, 0, 32'h12345678, 0};
        vecs[2]  = '{0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 7, 7, 0, 0, 0, 1, 0, 0, 1, 0, 1};
        vecs[4]  = '{1, 7, 32'hA5, 0, 7, 7, 7, 32'hA5, 32'hA5, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 1, 9, 7, 0, 32'hA5, 0, 0, 0, 1, 1, 32'hA5, 0};
        vecs[6]  = '{1, 9, 32'h55, 1, 9, 9, 0, 32'h55, 0, 0, 0, 1, 1, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 9, 9, 0, 32'h55, 0, 1, 0, 0, 1, 32'h55, 1};
        vecs[8]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 9, 0, 32'h55, 0, 1, 1, 1, 0, 0};
        vecs[9]  = '{1, 9, 32'h66, 0, 0, 0, 9, 0, 32'h66, 0, 0, 1, 0, 32'hFFFFFFFF, 1};
        vecs[10] = '{1, 12, 32'h77, 0, 0, 12, 9, 32'h77, 32'h66, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 12, 9, 32'h77, 32'h66, 0, 0, 1, 0, 32'h77, 0};

        reset = 1'b0;
        wb_en = 0; wb_addr = 0; wb_data = 0; issue_en = 0; issue_dst = 0;
        rd_addr_a = 0; rd_addr_b = 0;
        model_reset();
        #2;
        check_output("reset_count", 32'(busy_count), 0);
        check_output("reset_ready", 32'(issue_ready), 1);
        check_output("reset_busy_a", 32'(busy_a), 0);
        #10 reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].wb_en[0], vecs[i].wb_addr[4:0], vecs[i].wb_data,
                           vecs[i].issue_en[0], vecs[i].issue_dst[4:0],
                           vecs[i].rd_a[4:0], vecs[i].rd_b[4:0]);
            check_output($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].exp_a);
            check_output($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].exp_b);
            check_output($sformatf("vec%0d_busy_a", i), 32'(busy_a), vecs[i].exp_busy_a);
            check_output($sformatf("vec%0d_busy_b", i), 32'(busy_b), vecs[i].exp_busy_b);
            check_output($sformatf("vec%0d_ready", i), 32'(issue_ready), vecs[i].exp_ready);
            check_output($sformatf("vec%0d_alt_rd_a", i), alt_rd_data_a, vecs[i].exp_alt_a);
            check_output($sformatf("vec%0d_alt_busy_a", i), 32'(alt_busy_a), vecs[i].exp_alt_busy_a);
            commit_cycle();
            check_output($sformatf("vec%0d_count", i), 32'(busy_count), vecs[i].exp_count);
        end

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, id, ra, rb;
            wa = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            id = 5'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 1) != 0 ? wa : id);
            apply_stimulus(1'($urandom_range(0, 1)), wa, $urandom,
                           1'($urandom_range(0, 9) < 6), id, ra, rb);
            check_output("rand_rd_a", rd_data_a, model_read(rd_addr_a));
            check_output("rand_rd_b", rd_data_b, model_read(rd_addr_b));
            check_output("rand_busy_a", 32'(busy_a), 32'(model_busy(rd_addr_a)));
            check_output("rand_busy_b", 32'(busy_b), 32'(model_busy(rd_addr_b)));
            check_output("rand_ready", 32'(issue_ready), 32'(model_ready()));
            commit_cycle();
            check_output("rand_count", 32'(busy_count), model_count());
        end

        // Asynchronous reset in the middle of a cycle with state pending.
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        commit_cycle();
        model_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6);
        commit_cycle();
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd5, 5'd6);
        check_output("pre_reset_rd5", rd_data_a, 32'hDEADBEEF);
        check_output("pre_reset_count", 32'(busy_count), 1);
        check_output("pre_reset_ready", 32'(issue_ready), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_rd5", rd_data_a, 0);
        check_output("async_reset_count", 32'(busy_count), 0);
        check_output("async_reset_ready", 32'(issue_ready), 1);
        check_output("async_reset_busy_b", 32'(busy_b), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Fill r1..r31, then drain them all.
        for (int i = 1; i < 32; i++) begin
            apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i), 5'd0);
            check_output($sformatf("fill%0d_ready", i), 32'(issue_ready), 1);
            commit_cycle();
            check_output($sformatf("fill%0d_count", i), 32'(busy_count), i);
        end
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        check_output("full_reissue_ready", 32'(issue_ready), 0);
        check_output("full_busy_a", 32'(busy_a), 1);
        commit_cycle();
        check_output("full_count", 32'(busy_count), 31);
        for (int i = 1; i < 32; i++) begin
            apply_stimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'(i), 5'd0);
            check_output($sformatf("drain%0d_busy_a", i), 32'(busy_a), 0);
            check_output($sformatf("drain%0d_rd_a", i), rd_data_a, 32'(i) * 32'h01010101);
            commit_cycle();
            check_output($sformatf("drain%0d_count", i), 32'(busy_count), 31 - i);
        end
        apply_stimulus(1'b1, 5'd4, 32'hCAFEF00D, 1'b0, 5'd0, 5'd4, 5'd0);
        commit_cycle();
        check_output("nonbusy_wb_count", 32'(busy_count), 0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        check_output("nonbusy_wb_data", rd_data_a, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
